// File: rtl/frame_aligner.sv
// frame_aligner: serial frame aligner. Hunts for SYNC_WORD bit by bit, confirms lock over
// LOCK_CNT frames, then emits payload words with a 1-cycle valid strobe. Outputs lag the last
// bit of a word by one edge. Optional sync-miss counter enabled by defining ALIGN_ERR_CNT_EN.
module frame_aligner #(
  parameter int          WORD_W    = 32,
  parameter logic [31:0] SYNC_WORD = 32'hA5C3_0F96,
  parameter int          FRAME_LEN = 8,
  parameter int          LOCK_CNT  = 3,
  parameter int          LOSS_CNT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_start,
  output logic              locked,
  output logic [15:0]       err_cnt
);

  localparam int BCW = $clog2(WORD_W);
  localparam int WCW = $clog2(FRAME_LEN);
  localparam int GCW = $clog2(LOCK_CNT + 1);
  localparam int MCW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [BCW-1:0]    bit_cnt;
  logic [WCW-1:0]    word_cnt;
  logic [GCW-1:0]    good;
  logic [MCW-1:0]    miss;

  logic              sync_hit;
  logic              bit_last;
  logic              word_last;
  logic              sync_slot;
  logic [GCW-1:0]    good_nxt;
  logic [MCW-1:0]    miss_nxt;

  // sreg holds a complete word in the cycle where bit_cnt sits on its last value
  assign sync_hit  = (sreg == SYNC_WORD[WORD_W-1:0]);
  assign bit_last  = (bit_cnt == BCW'(WORD_W - 1));
  assign word_last = (word_cnt == WCW'(FRAME_LEN - 1));
  assign sync_slot = bit_last && (word_cnt == '0);
  assign good_nxt  = good + 1'b1;
  assign miss_nxt  = miss + 1'b1;

  // Shift register, bit/word framing counters and the alignment state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      sreg        <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      good        <= '0;
      miss        <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
    end else begin
      sreg        <= {sreg[WORD_W-2:0], data_in};
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      bit_cnt     <= bit_last ? '0 : bit_cnt + 1'b1;
      if (bit_last) begin
        word_cnt <= word_last ? '0 : word_cnt + 1'b1;
      end

      unique case (state)
        HUNT: begin
          // Bit-slip search: any cycle may be the end of a sync word
          if (sync_hit) begin
            bit_cnt  <= '0;
            word_cnt <= WCW'(1);
            good     <= GCW'(1);
            miss     <= '0;
            if (LOCK_CNT == 1) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state  <= VERIFY;
            end
          end
        end

        VERIFY: begin
          // Payload that happens to equal SYNC_WORD is ignored here: only slot 0 is checked
          if (sync_slot) begin
            if (sync_hit) begin
              good <= good_nxt;
              if (good_nxt == GCW'(LOCK_CNT)) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= '0;
              end
            end else begin
              state <= HUNT;
              good  <= '0;
            end
          end
        end

        LOCKED: begin
          if (bit_last) begin
            if (word_cnt == '0) begin
              if (sync_hit) begin
                miss <= '0;
              end else if (miss_nxt == MCW'(LOSS_CNT)) begin
                state  <= HUNT;
                locked <= 1'b0;
                miss   <= '0;
                good   <= '0;
              end else begin
                // Flywheel: keep framing and emitting payload across isolated misses
                miss <= miss_nxt;
              end
            end else begin
              data_out    <= sreg;
              data_valid  <= 1'b1;
              frame_start <= (word_cnt == WCW'(1));
            end
          end
        end

        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALIGN_ERR_CNT_EN
  logic miss_evt;

  // A miss only counts once framing is established (VERIFY or LOCKED)
  assign miss_evt = sync_slot && !sync_hit && (state != HUNT);

  // Saturating sync-miss counter
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (miss_evt && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_aligner.sv
// tb_frame_aligner: directed frame table plus a mid-payload reset sequence for frame_aligner.
// Each frame's sync-slot outputs are sampled one edge after its last sync bit; payload pulses
// collected since the previous sync sample are compared against the previous frame's record.
module tb_frame_aligner;

  localparam logic [31:0] SYNC = 32'hA5C3_0F96;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_in = 1'b0;
  logic [31:0] data_out;
  logic        data_valid;
  logic        frame_start;
  logic        locked;
  logic [15:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  frame_aligner dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_start (frame_start),
    .locked      (locked),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sync;   // word sent in the sync slot
    logic [31:0] base;   // payload word k = base + k
    logic        psync;  // payload word 3 replaced by SYNC
    logic        lock;   // expected locked after this sync boundary
    int          err;    // expected err_cnt after this sync boundary
    int          np;     // payload pulses this frame must produce
  } rec_t;

  rec_t tbl [21];

  // Captured payload pulses
  logic [31:0] q_dat [$];
  logic        q_fs  [$];

  int          prev_np    = 0;
  logic [31:0] prev_base  = '0;
  logic        prev_psync = 1'b0;

  always @(negedge clk) begin
    if (data_valid) begin
      q_dat.push_back(data_out);
      q_fs.push_back(frame_start);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_err(input int e);
`ifdef ALIGN_ERR_CNT_EN
    return 32'(e);
`else
    return (e == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic sync_sample(input int idx);
    logic [31:0] w;
    check($sformatf("f%0d locked", idx), 32'(locked), 32'(tbl[idx].lock));
    check($sformatf("f%0d err_cnt", idx), 32'(err_cnt), exp_err(tbl[idx].err));
    check($sformatf("f%0d pulses_prev", idx), 32'(q_dat.size()), 32'(prev_np));
    if (q_dat.size() == prev_np && prev_np == 7) begin
      for (int k = 0; k < 7; k++) begin
        w = (prev_psync && k == 2) ? SYNC : prev_base + 32'(k + 1);
        check($sformatf("f%0d word%0d", idx, k + 1), q_dat[k], w);
        check($sformatf("f%0d fs%0d", idx, k + 1), 32'(q_fs[k]), 32'(k == 0));
      end
    end
    q_dat.delete();
    q_fs.delete();
    prev_np    = tbl[idx].np;
    prev_base  = tbl[idx].base;
    prev_psync = tbl[idx].psync;
  endtask

  // Send one full frame; optionally pulse rst on bit number rst_at
  task automatic send_frame(input int idx, input int rst_at);
    logic [31:0] w;
    int bitno;
    bitno = 0;
    for (int wd = 0; wd < 8; wd++) begin
      if (wd == 0)                       w = tbl[idx].sync;
      else if (tbl[idx].psync && wd == 3) w = SYNC;
      else                               w = tbl[idx].base + 32'(wd);
      for (int b = 31; b >= 0; b--) begin
        data_in = w[b];
        rst     = (bitno == rst_at);
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (bitno == 32) sync_sample(idx);
        if (bitno == rst_at) begin
          check("rst locked", 32'(locked), 32'd0);
          check("rst err_cnt", 32'(err_cnt), 32'd0);
          check("rst data_valid", 32'(data_valid), 32'd0);
          check("rst data_out", data_out, 32'd0);
          prev_np = 0;
        end
        bitno++;
      end
    end
  endtask

  initial begin
    //            sync          base            psync lock err np
    tbl[0]  = '{SYNC,        32'h0,          1'b0, 1'b0, 0, 0};
    tbl[1]  = '{SYNC,        32'h0,          1'b0, 1'b0, 0, 0};
    tbl[2]  = '{SYNC,        32'h0,          1'b0, 1'b1, 0, 7};
    tbl[3]  = '{SYNC,        32'h0,          1'b0, 1'b1, 0, 7};
    tbl[4]  = '{32'h0,       32'h0000_0100,  1'b0, 1'b1, 1, 7};
    tbl[5]  = '{SYNC,        32'h0000_0200,  1'b0, 1'b1, 1, 7};
    tbl[6]  = '{32'h0,       32'h0000_0300,  1'b0, 1'b1, 2, 7};
    tbl[7]  = '{32'h0,       32'h0,          1'b0, 1'b0, 3, 0};
    tbl[8]  = '{SYNC,        32'h0,          1'b0, 1'b0, 3, 0};
    tbl[9]  = '{SYNC,        32'h0,          1'b0, 1'b0, 3, 0};
    tbl[10] = '{32'h0,       32'h0,          1'b0, 1'b0, 4, 0};
    tbl[11] = '{SYNC,        32'h0,          1'b0, 1'b0, 4, 0};
    tbl[12] = '{SYNC,        32'h0,          1'b0, 1'b0, 4, 0};
    tbl[13] = '{SYNC,        32'hDEAD_0000,  1'b0, 1'b1, 4, 7};
    tbl[14] = '{SYNC,        32'h0000_5000,  1'b1, 1'b1, 4, 7};
    tbl[15] = '{SYNC,        32'h0000_6000,  1'b0, 1'b1, 4, 7};
    tbl[16] = '{SYNC,        32'h0,          1'b0, 1'b1, 4, 0};
    tbl[17] = '{SYNC,        32'h0,          1'b0, 1'b0, 0, 0};
    tbl[18] = '{SYNC,        32'h0,          1'b0, 1'b0, 0, 0};
    tbl[19] = '{SYNC,        32'h0000_7000,  1'b0, 1'b1, 0, 7};
    tbl[20] = '{SYNC,        32'h0,          1'b0, 1'b1, 0, 7};

    // Reset held 5 cycles with random serial data
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      data_in = 1'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("reset%0d locked", c), 32'(locked), 32'd0);
      check($sformatf("reset%0d data_valid", c), 32'(data_valid), 32'd0);
      check($sformatf("reset%0d frame_start", c), 32'(frame_start), 32'd0);
      check($sformatf("reset%0d data_out", c), data_out, 32'd0);
      check($sformatf("reset%0d err_cnt", c), 32'(err_cnt), 32'd0);
    end
    rst = 1'b0;

    // 7 junk bits before the first frame
    for (int j = 0; j < 7; j++) begin
      data_in = 1'b0;
      @(posedge clk);
      #1;
    end

    // Lock, flywheel, loss, verify failure, relock, sync-valued payload
    for (int i = 0; i < 16; i++) send_frame(i, -1);

    // Reset pulsed in the middle of payload word 1 while locked
    send_frame(16, 50);

    // Relock after reset
    for (int i = 17; i < 21; i++) send_frame(i, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
